// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_pkg
// Purpose  : Shared constants for the JPEG quantizer: lane/reciprocal widths,
//            reciprocal table depth, rounding shift/constant and the reset
//            value of every reciprocal entry (Q=1).
// Revision : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

  localparam int DW          = 12;   // coefficient lane width (two's complement)
  localparam int RW          = 16;   // reciprocal width, round(65536/Q)
  localparam int LANES       = 8;    // rows per column vector
  localparam int TBL_DEPTH   = 64;   // one entry per {col,row}
  localparam int ROUND_SHIFT = 16;
  localparam int ROUND_CONST = 1 << (ROUND_SHIFT - 1);
  localparam logic [15:0] RECIP_DEFAULT = 16'hFFFF;  // Q=1

endpackage
`default_nettype wire

// File: rtl/jpeg_quant_if.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quant_if
// Purpose  : Bundles the quantizer's input stream, output stream and
//            reciprocal-table write port.
//   slave  : view used by jpeg_quant (consumes in_*, tbl_*, drives out_*)
//   master : view used by the surrounding logic / bench
// Revision : 1.0 - initial release
// ============================================================================
interface jpeg_quant_if
  import jpeg_pkg::*;
#(
  parameter int DW = jpeg_pkg::DW,
  parameter int RW = jpeg_pkg::RW
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0][DW-1:0] in_data;
  logic                    tbl_we;
  logic [5:0]              tbl_addr;
  logic [RW-1:0]           tbl_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0][DW-1:0] out_data;
  logic [2:0]              out_col;
  logic                    out_eob;

  modport slave (
    input  in_valid, in_data, tbl_we, tbl_addr, tbl_data, out_ready,
    output in_ready, out_valid, out_data, out_col, out_eob
  );

  modport master (
    output in_valid, in_data, tbl_we, tbl_addr, tbl_data, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_eob
  );

endinterface
`default_nettype wire

// File: rtl/jpeg_quant_lane.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quant_lane
// Purpose  : One quantizer lane. Stage 1 registers the signed product
//            coef*recip; stage 2 registers the rounded (half up), saturated
//            quotient.
// Ports    : clk, rst_n       - clock, async active-low reset
//            load_s1, load_s2 - stage register enables
//            coef             - signed input coefficient
//            recip            - unsigned reciprocal round(65536/Q)
//            q                - registered quantized result
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_quant_lane
  import jpeg_pkg::*;
#(
  parameter int DW = jpeg_pkg::DW,
  parameter int RW = jpeg_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_s1,
  input  logic          load_s2,
  input  logic [DW-1:0] coef,
  input  logic [RW-1:0] recip,
  output logic [DW-1:0] q
);

  localparam int PW = DW + RW + 1;

  // Limits and rounding constant carried at PW+1 bits so the comparisons
  // see the full post-shift value without truncation.
  localparam logic signed [PW:0] c_SAT_MAX = (PW+1)'((1 <<< (DW-1)) - 1);
  localparam logic signed [PW:0] c_SAT_MIN = (PW+1)'(-(1 <<< (DW-1)));
  localparam logic signed [PW:0] c_ROUND   = (PW+1)'(ROUND_CONST);

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_prod;
  logic signed [PW:0]   w_sum;
  logic signed [PW:0]   w_shift;
  logic        [DW-1:0] w_sat;
  logic        [DW-1:0] r_q;

  // The reciprocal is unsigned: zero-extend it so the multiply stays signed.
  assign w_a    = PW'($signed(coef));
  assign w_b    = PW'({1'b0, recip});
  assign w_prod = w_a * w_b;

  assign w_sum   = $signed({r_prod[PW-1], r_prod}) + c_ROUND;
  assign w_shift = w_sum >>> ROUND_SHIFT;

  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > c_SAT_MAX) begin
      w_sat = c_SAT_MAX[DW-1:0];
    end else if (w_shift < c_SAT_MIN) begin
      w_sat = c_SAT_MIN[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_q    <= '0;
    end else begin
      if (load_s1) r_prod <= w_prod;
      if (load_s2) r_q    <= w_sat;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jpeg_quant.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_quant
// Purpose  : JPEG quantizer for 8-lane column vectors. Multiplies each lane
//            by a per-position reciprocal from a 64-entry table, then rounds
//            and saturates in a two-stage valid/ready pipeline.
// Ports    : clk     - clock
//            rst_n   - async active-low reset
//            restart - synchronous soft clear (pipeline + column counter)
//            bus     - jpeg_quant_if.slave: in stream, out stream, table port
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_quant
  import jpeg_pkg::*;
#(
  parameter int DW = jpeg_pkg::DW,
  parameter int RW = jpeg_pkg::RW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  jpeg_quant_if.slave  bus
);

  logic [RW-1:0]             r_tbl [TBL_DEPTH];
  logic [2:0]                r_col;
  logic                      r_s1_valid;
  logic [2:0]                r_s1_col;
  logic                      r_s2_valid;
  logic [2:0]                r_s2_col;
  logic                      w_s2_load;
  logic                      w_s1_adv;
  logic                      w_in_ready;
  logic                      w_in_fire;
  logic [LANES-1:0][DW-1:0]  w_q;

  // S2 may take new data when empty or being drained this cycle; S1 frees
  // up when it is empty or moving into S2.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_in_fire  = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_col      <= 3'd0;
      r_s1_col   <= 3'd0;
      r_s2_col   <= 3'd0;
    end else if (restart) begin
      // A vector offered in the restart cycle is dropped.
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_col      <= 3'd0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_col   <= r_col;
        r_col      <= r_col + 3'd1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s1_adv)  r_s2_col   <= r_s1_col;
    end
  end

  // Reciprocal table; reads happen combinationally in the transfer cycle,
  // so a same-cycle write is only seen by later vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        r_tbl[i] <= RW'(RECIP_DEFAULT);
      end
    end else if (bus.tbl_we) begin
      r_tbl[bus.tbl_addr] <= bus.tbl_data;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [RW-1:0] w_recip;
    assign w_recip = r_tbl[{r_col, 3'(g)}];

    jpeg_quant_lane #(
      .DW (DW),
      .RW (RW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_s1 (w_in_fire && !restart),
      .load_s2 (w_s1_adv && !restart),
      .coef    (bus.in_data[g]),
      .recip   (w_recip),
      .q       (w_q[g])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = w_q;
  assign bus.out_col   = r_s2_col;
  assign bus.out_eob   = (r_s2_col == 3'd7);

endmodule
`default_nettype wire

// File: tb/tb_jpeg_quant.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_quant
// Purpose  : Self-checking bench for jpeg_quant: directed table of vectors,
//            hand-written multi-cycle sequences and a randomized stream
//            scored against a behavioural quantizer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_quant;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic restart = 1'b0;

  jpeg_quant_if bus ();

  jpeg_quant dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][11:0] data;
    int               col;
  } exp_t;

  typedef struct {
    bit   we;
    int   addr;
    int   recip;
    int   lane[8];
    int   exp[8];
  } rec_t;

  int  n_tests = 0;
  int  n_fail  = 0;

  int   m_tbl[64];
  int   m_col;
  exp_t sb[$];

  bit               hold_pend;
  logic [7:0][11:0] hold_data;
  bit               last_fi, last_fo, s_in_ready, s_out_valid;
  logic [7:0][11:0] last_data;
  int               last_col;
  bit               last_eob;

  rec_t recs[6];

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Quotient of x / Q with the reciprocal r = 65536/Q, rounded half up,
  // clamped to the 12-bit signed range.
  function automatic logic [11:0] ref_q(int x, int r);
    longint p;
    p = (longint'(x) * longint'(r) + 64'sd32768) >>> 16;
    if (p > 2047)  p = 2047;
    if (p < -2048) p = -2048;
    return p[11:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 65535;
    m_col = 0;
    sb.delete();
    hold_pend = 0;
  endtask

  // One clock cycle: sample away from the edge, score handshakes, advance.
  task automatic cycle();
    bit   fi, fo;
    exp_t e;
    #1;
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    fi = bus.in_valid && bus.in_ready;
    fo = bus.out_valid && bus.out_ready;
    if (hold_pend) begin
      chk("hold_valid", 96'(bus.out_valid), 96'd1);
      chk("hold_data", bus.out_data, hold_data);
    end
    hold_pend = bus.out_valid && !bus.out_ready && !restart;
    hold_data = bus.out_data;
    if (fo) begin
      last_data = bus.out_data;
      last_col  = int'(bus.out_col);
      last_eob  = bus.out_eob;
      if (sb.size() == 0) begin
        chk("spurious_out", 96'd1, 96'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_col", 96'(bus.out_col), 96'(e.col));
        chk("sb_eob", 96'(bus.out_eob), 96'(e.col == 7));
      end
    end
    if (restart) begin
      sb.delete();
      m_col = 0;
    end else if (fi) begin
      for (int r = 0; r < 8; r++) begin
        e.data[r] = ref_q(int'($signed(bus.in_data[r])), m_tbl[m_col*8 + r]);
      end
      e.col = m_col;
      sb.push_back(e);
      m_col = (m_col + 1) % 8;
    end
    if (bus.tbl_we) m_tbl[bus.tbl_addr] = int'(bus.tbl_data);
    last_fi = fi;
    last_fo = fo;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lanes(input int lanes[8]);
    for (int r = 0; r < 8; r++) bus.in_data[r] = 12'(lanes[r]);
  endtask

  task automatic send_vec(input int lanes[8]);
    set_lanes(lanes);
    bus.in_valid = 1'b1;
    last_fi = 0;
    for (int k = 0; k < 20 && !last_fi; k++) cycle();
    bus.in_valid = 1'b0;
    if (!last_fi) chk("in_timeout", 96'd0, 96'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    last_fo = 0;
    for (int k = 0; k < 20 && !last_fo; k++) begin
      cycle();
      lat++;
    end
    if (!last_fo) chk("out_timeout", 96'd0, 96'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
  endtask

  task automatic rand_lanes();
    for (int r = 0; r < 8; r++) bus.in_data[r] = 12'($urandom);
  endtask

  initial begin
    int lat;
    int lanes[8];
    int cols[9];
    bit eobs[9];
    int n_in, n_out;

    recs[0] = '{we:0, addr:0, recip:0,
                lane:'{2047, -2048, 1, -1, 0, 100, -100, 5},
                exp :'{2047, -2048, 1, -1, 0, 100, -100, 5}};
    recs[1] = '{we:1, addr:0, recip:4096,
                lane:'{100, 7, -7, 300, -300, 0, 1, -1},
                exp :'{6, 7, -7, 300, -300, 0, 1, -1}};
    recs[2] = '{we:0, addr:0, recip:0,
                lane:'{-8, 2047, -2048, 50, -50, 9, -9, 0},
                exp :'{0, 2047, -2048, 50, -50, 9, -9, 0}};
    recs[3] = '{we:1, addr:0, recip:40000,
                lane:'{2047, 0, 0, 0, 0, 0, 0, 0},
                exp :'{1249, 0, 0, 0, 0, 0, 0, 0}};
    recs[4] = '{we:1, addr:1, recip:40000,
                lane:'{-2048, -2048, 0, 0, 0, 0, 0, 0},
                exp :'{-1250, -1250, 0, 0, 0, 0, 0, 0}};
    recs[5] = '{we:1, addr:0, recip:65535,
                lane:'{2047, 2047, -2048, 0, 0, 0, 0, 0},
                exp :'{2047, 1249, -2048, 0, 0, 0, 0, 0}};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_out_data",  bus.out_data, 96'd0);
    chk("rst_out_col",   96'(bus.out_col), 96'd0);
    chk("rst_out_eob",   96'(bus.out_eob), 96'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("rst_in_ready", 96'(s_in_ready), 96'd1);

    // Directed table: restart, optional table write, one vector.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse_restart();
      if (recs[i].we) begin
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = 6'(recs[i].addr);
        bus.tbl_data = 16'(recs[i].recip);
        cycle();
        bus.tbl_we   = 1'b0;
      end
      send_vec(recs[i].lane);
      wait_out(lat);
      chk("rec_latency", 96'(lat), 96'd2);
      chk("rec_col", 96'(last_col), 96'd0);
      for (int r = 0; r < 8; r++) begin
        chk("rec_lane", 96'($signed(last_data[r])), 96'(recs[i].exp[r]));
      end
    end

    // Same-cycle table write and transfer: old entry used, new one next.
    pulse_restart();
    lanes = '{0, 0, 160, 0, 0, 0, 0, 0};
    set_lanes(lanes);
    bus.in_valid = 1'b1;
    bus.tbl_we = 1'b1; bus.tbl_addr = 6'd2; bus.tbl_data = 16'd4096;
    cycle();
    bus.in_valid = 1'b0; bus.tbl_we = 1'b0;
    chk("wr_same_fire", 96'(last_fi), 96'd1);
    wait_out(lat);
    chk("wr_same_old", 96'($signed(last_data[2])), 96'd160);
    pulse_restart();
    send_vec(lanes);
    wait_out(lat);
    chk("wr_next_new", 96'($signed(last_data[2])), 96'd10);

    // Nine back-to-back vectors.
    pulse_restart();
    n_in = 0; n_out = 0;
    for (int k = 0; k < 30 && n_out < 9; k++) begin
      bus.in_valid = (n_in < 9);
      rand_lanes();
      cycle();
      if (last_fi) n_in++;
      if (last_fo) begin
        cols[n_out] = last_col;
        eobs[n_out] = last_eob;
        n_out++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", 96'(n_out), 96'd9);
    for (int k = 0; k < 9; k++) begin
      chk("b2b_col", 96'(cols[k]), 96'(k % 8));
      chk("b2b_eob", 96'(eobs[k]), 96'(k == 7));
    end

    // Five-cycle downstream stall in a stream.
    pulse_restart();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.out_ready = !(k >= 4 && k < 9);
      rand_lanes();
      cycle();
      if (k == 6) chk("stall_in_ready", 96'(s_in_ready), 96'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    chk("stall_drained", 96'(sb.size()), 96'd0);

    // Restart with two vectors in flight and in_valid high.
    pulse_restart();
    bus.in_valid = 1'b1;
    rand_lanes(); cycle();
    rand_lanes(); cycle();
    restart = 1'b1;
    rand_lanes(); cycle();
    restart = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    chk("restart_out_valid", 96'(s_out_valid), 96'd0);
    lanes = '{3, -3, 33, -33, 333, -333, 1000, -1000};
    send_vec(lanes);
    wait_out(lat);
    chk("restart_col", 96'(last_col), 96'd0);

    // Reset mid-block: in-flight vectors dropped, table back to Q=1.
    bus.in_valid = 1'b1;
    repeat (3) begin rand_lanes(); cycle(); end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 96'(bus.out_valid), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lanes = '{10, -20, 30, -40, 50, -60, 70, -80};
    send_vec(lanes);
    wait_out(lat);
    chk("midrst_col", 96'(last_col), 96'd0);
    chk("midrst_lane0", 96'($signed(last_data[0])), 96'd10);

    // Randomized stream scored against the model.
    for (int k = 0; k < 1500; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_lanes();
      bus.tbl_we    = ($urandom_range(0, 15) == 0);
      bus.tbl_addr  = 6'($urandom_range(0, 63));
      bus.tbl_data  = 16'($urandom_range(1, 65535));
      restart       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.tbl_we   = 1'b0;
    restart      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    chk("rand_drained", 96'(sb.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jpeg_quant.md
JPEG_QUANT -- requirements
Module: jpeg_quant

Interface
REQ-001 Parameter DW, default 12: coefficient lane width, two's complement.
REQ-002 Parameter RW, default 16: reciprocal width, unsigned, value = round(65536/Q), Q=1 encoded as 16'hFFFF.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port restart  input  1  synchronous soft clear: flush pipeline and restart at column 0.
REQ-006 Port in_valid  input  1  in_data holds a column vector from the column-pass transpose/DCT stage.
REQ-007 Port in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port in_data  input  [7:0][DW-1:0]  column vector; lane r = row r.
REQ-009 Port tbl_we  input  1  reciprocal table write strobe.
REQ-010 Port tbl_addr  input  6  table index = {col[2:0], row[2:0]}.
REQ-011 Port tbl_data  input  RW  reciprocal written.
REQ-012 Port out_valid  output  1  out_data valid.
REQ-013 Port out_ready  input  1  downstream accepts out_data.
REQ-014 Port out_data  output  [7:0][DW-1:0]  quantized column vector.
REQ-015 Port out_col  output  3  column index of out_data.
REQ-016 Port out_eob  output  1  high with the column-7 vector (end of 8x8 block).

Function
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Datapath SHALL be a two-stage pipeline: S1 registers 8 signed products in*recip (DW+RW+1 bits), S2 registers rounded, saturated results.
REQ-019 Stage advance: S2 loads when !out_valid || out_ready; S1 loads when S1 empty or S1 advances into S2; in_ready = S1 empty || S1 advancing.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid when out_ready is held high; sustained throughput 1 vector/cycle.
REQ-021 out_data SHALL hold stable while out_valid && !out_ready; no vector lost or duplicated under any in_valid/out_ready pattern.
REQ-022 Rounding: q = (p + 2^15) >>> 16 (arithmetic shift, round half up).
REQ-023 Saturation: q clamped to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 Column counter (3 bits) SHALL increment per input transfer, wrap 7->0; its value travels with the vector to out_col; out_eob = (out_col==7).
REQ-025 Reciprocal lookup for lane r SHALL use table[{col,r}], read at input transfer.
REQ-026 Table write and input transfer in same cycle: transferred vector uses old entry; write visible from next cycle.
REQ-027 restart SHALL clear S1/S2 valid and column counter next cycle, override simultaneous input transfer (vector dropped), leave table unchanged.

Reset
REQ-028 On rst_n low, asynchronously: out_valid=0, in_ready=1 after deassertion, column counter=0, out_col=0, out_eob=0, out_data=0, all 64 table entries=16'hFFFF.
REQ-029 Reset mid-block SHALL discard in-flight vectors; first vector after reset is column 0.

Structure
REQ-030 DW, RW, table depth 64, rounding constant and 16'hFFFF default SHALL live in shared package jpeg_pkg.
REQ-031 One sub-module jpeg_quant_lane (multiply, round, saturate for one lane) SHALL be instantiated 8 times.

Verification
REQ-032 Default table, in lanes {2047,-2048,1,-1,0,100,-100,5}, out_ready=1 -> out_data identical, 2 cycles later, out_col=0.
REQ-033 Write table[{0,0}]=4096 (Q=16), input lane0=100 -> output 6 (100/16=6.25); lane0=-8 -> 0 (-0.5 rounds up).
REQ-034 Eight back-to-back vectors -> out_col 0..7, out_eob only on 8th, ninth vector out_col=0.
REQ-035 out_ready low 5 cycles during stream -> in_ready low after pipeline fills, out_data stable, all vectors delivered in order.
REQ-036 Table entry 16'hFFFF with a forced product overflow via entry written with in=2047, recip=65535 then recip=40000 on Q-scaled inputs -> results clamped to 2047/-2048 as applicable.
REQ-037 restart asserted with 2 vectors in flight and in_valid high -> out_valid low next cycle, next accepted vector out_col=0.
